// File: rtl/color_pkg.sv
// color_pkg: shared types for the colour descrambler.
//   sel_e        - channel select (R, G, B or constant zero)
//   key_t        - scramble key, one select per output channel
//   KEY_IDENTITY - key that leaves pixels unchanged
//   state_e      - key-swap FSM states
//   key_is_perm  - true when a key is a permutation of {R, G, B}
package color_pkg;

  localparam int unsigned CH_W  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_R    = 2'd0,
    SEL_G    = 2'd1,
    SEL_B    = 2'd2,
    SEL_ZERO = 2'd3
  } sel_e;

  typedef struct packed {
    sel_e r;
    sel_e g;
    sel_e b;
  } key_t;

  localparam key_t KEY_IDENTITY = '{r: SEL_R, g: SEL_G, b: SEL_B};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // A key is invertible only if every select is a real channel and none repeat.
  function automatic logic key_is_perm(input key_t k);
    return (k.r != SEL_ZERO) && (k.g != SEL_ZERO) && (k.b != SEL_ZERO) &&
           (k.r != k.g) && (k.r != k.b) && (k.g != k.b);
  endfunction

endpackage

// File: rtl/color_inv_sel.sv
// color_inv_sel: recovers one output channel from a scrambled pixel.
//   CHAN    - which channel this instance recovers
//   key_i   - active scramble key
//   r_i/g_i/b_i - scrambled channel inputs
//   pix_c_o - recovered channel (combinational)
module color_inv_sel
  import color_pkg::*;
#(
  parameter sel_e CHAN = SEL_R
) (
  input  key_t            key_i,
  input  logic [CH_W-1:0] r_i,
  input  logic [CH_W-1:0] g_i,
  input  logic [CH_W-1:0] b_i,
  output logic [CH_W-1:0] pix_c_o
);

  // Fixed priority r > g > b resolves duplicated selects; no match yields zero.
  always_comb begin
    pix_c_o = '0;
    if (key_i.r == CHAN) begin
      pix_c_o = r_i;
    end else if (key_i.g == CHAN) begin
      pix_c_o = g_i;
    end else if (key_i.b == CHAN) begin
      pix_c_o = b_i;
    end
  end

endmodule

// File: rtl/color_descra.sv
// color_descra: two-stage colour channel descrambler with frame-aligned key swap.
//   clk, reset                  - clock, synchronous active-high reset
//   key_valid/key_ready         - key offer handshake
//   key_sw_r/key_sw_g/key_sw_b  - offered scramble key
//   in_valid/in_sof/in_r/g/b    - scrambled pixel stream
//   out_valid/out_sof/out_r/g/b - recovered pixel stream, 2-cycle latency
//   key_err                     - active key is not invertible
module color_descra
  import color_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            key_valid,
  input  logic [1:0]      key_sw_r,
  input  logic [1:0]      key_sw_g,
  input  logic [1:0]      key_sw_b,
  output logic            key_ready,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [CH_W-1:0] in_r,
  input  logic [CH_W-1:0] in_g,
  input  logic [CH_W-1:0] in_b,
  output logic            out_valid,
  output logic            out_sof,
  output logic [CH_W-1:0] out_r,
  output logic [CH_W-1:0] out_g,
  output logic [CH_W-1:0] out_b,
  output logic            key_err
);

  state_e          state_q;
  key_t            active_q;
  key_t            pending_q;
  logic            key_ready_q;
  logic            key_err_q;

  logic            s1_valid_q;
  logic            s1_sof_q;
  logic [CH_W-1:0] s1_r_q;
  logic [CH_W-1:0] s1_g_q;
  logic [CH_W-1:0] s1_b_q;
  key_t            s1_key_q;

  logic            out_valid_q;
  logic            out_sof_q;
  logic [CH_W-1:0] out_r_q;
  logic [CH_W-1:0] out_g_q;
  logic [CH_W-1:0] out_b_q;

  logic            swap_d;
  key_t            pix_key_d;
  key_t            key_in_d;
  logic [CH_W-1:0] map_r_c;
  logic [CH_W-1:0] map_g_c;
  logic [CH_W-1:0] map_b_c;

  // A pending key takes effect on the sof pixel itself, so that pixel sees it directly.
  assign swap_d    = (state_q == ST_PEND) && in_valid && in_sof;
  assign pix_key_d = swap_d ? pending_q : active_q;
  assign key_in_d  = '{r: sel_e'(key_sw_r), g: sel_e'(key_sw_g), b: sel_e'(key_sw_b)};

  // Key-swap FSM: RUN accepts a key, PEND holds it until the next frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      active_q    <= KEY_IDENTITY;
      pending_q   <= KEY_IDENTITY;
      key_ready_q <= 1'b1;
      key_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (key_valid) begin
            pending_q   <= key_in_d;
            state_q     <= ST_PEND;
            key_ready_q <= 1'b0;
          end
        end
        ST_PEND: begin
          if (swap_d) begin
            active_q    <= pending_q;
            key_err_q   <= ~key_is_perm(pending_q);
            state_q     <= ST_RUN;
            key_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          key_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: capture pixel together with the key chosen for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_key_q   <= KEY_IDENTITY;
    end else begin
      s1_valid_q <= in_valid;
      s1_sof_q   <= in_valid & in_sof;
      s1_r_q     <= in_r;
      s1_g_q     <= in_g;
      s1_b_q     <= in_b;
      s1_key_q   <= pix_key_d;
    end
  end

  color_inv_sel #(.CHAN(SEL_R)) u_inv_r (
    .key_i   (s1_key_q),
    .r_i     (s1_r_q),
    .g_i     (s1_g_q),
    .b_i     (s1_b_q),
    .pix_c_o (map_r_c)
  );

  color_inv_sel #(.CHAN(SEL_G)) u_inv_g (
    .key_i   (s1_key_q),
    .r_i     (s1_r_q),
    .g_i     (s1_g_q),
    .b_i     (s1_b_q),
    .pix_c_o (map_g_c)
  );

  color_inv_sel #(.CHAN(SEL_B)) u_inv_b (
    .key_i   (s1_key_q),
    .r_i     (s1_r_q),
    .g_i     (s1_g_q),
    .b_i     (s1_b_q),
    .pix_c_o (map_b_c)
  );

  // Stage 2: register mapped pixel; idle cycles present zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_valid_q & s1_sof_q;
      out_r_q     <= s1_valid_q ? map_r_c : '0;
      out_g_q     <= s1_valid_q ? map_g_c : '0;
      out_b_q     <= s1_valid_q ? map_b_c : '0;
    end
  end

  assign key_ready = key_ready_q;
  assign key_err   = key_err_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_r     = out_r_q;
  assign out_g     = out_g_q;
  assign out_b     = out_b_q;

endmodule

// File: tb/tb_color_descra.sv
// tb_color_descra: scoreboard bench for color_descra with an independent key/pixel model.
module tb_color_descra;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [1:0] key_sw_r;
  logic [1:0] key_sw_g;
  logic [1:0] key_sw_b;
  logic       key_ready;
  logic       in_valid;
  logic       in_sof;
  logic [3:0] in_r;
  logic [3:0] in_g;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_sof;
  logic [3:0] out_r;
  logic [3:0] out_g;
  logic [3:0] out_b;
  logic       key_err;

  color_descra dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_sw_r  (key_sw_r),
    .key_sw_g  (key_sw_g),
    .key_sw_b  (key_sw_b),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .key_err   (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned due;
    logic        sof;
    logic [11:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_checks;
  int          n_errors;

  // Bench model of the key state; keys packed as {r, g, b}, 2 bits each.
  logic [5:0]  m_active;
  logic [5:0]  m_pending;
  bit          m_pend;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // For each output channel, scan sources from b up to r so the highest-priority match wins.
  function automatic logic [11:0] model_map(input logic [5:0] key, input logic [3:0] r,
                                            input logic [3:0] g, input logic [3:0] b);
    logic [3:0] src [3];
    logic [3:0] o   [3];
    src[0] = r;
    src[1] = g;
    src[2] = b;
    for (int x = 0; x < 3; x++) begin
      o[x] = 4'd0;
      for (int s = 2; s >= 0; s--) begin
        if (key[5-2*s -: 2] == 2'(x)) o[x] = src[s];
      end
    end
    return {o[0], o[1], o[2]};
  endfunction

  function automatic bit model_perm(input logic [5:0] k);
    logic [1:0] a;
    logic [1:0] bb;
    logic [1:0] c;
    a  = k[5:4];
    bb = k[3:2];
    c  = k[1:0];
    return (a != 2'd3) && (bb != 2'd3) && (c != 2'd3) && (a != bb) && (a != c) && (bb != c);
  endfunction

  // One clock: drive inputs, advance the model across the edge, then check outputs.
  task automatic step(input bit rst, input bit kv, input logic [5:0] key,
                      input bit v, input bit sof,
                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    logic [5:0] use_key;
    bit         swap;
    exp_t       e;
    bit         exp_vld;

    reset     = rst;
    key_valid = kv;
    key_sw_r  = key[5:4];
    key_sw_g  = key[3:2];
    key_sw_b  = key[1:0];
    in_valid  = v;
    in_sof    = sof;
    in_r      = r;
    in_g      = g;
    in_b      = b;

    swap    = m_pend && v && sof;
    use_key = swap ? m_pending : m_active;

    @(posedge clk);
    cyc++;

    if (rst) begin
      sb.delete();
      m_active  = 6'b00_01_10;
      m_pending = 6'b00_01_10;
      m_pend    = 1'b0;
      m_err     = 1'b0;
    end else begin
      if (v) begin
        e.due = cyc + 1;
        e.sof = sof;
        e.rgb = model_map(use_key, r, g, b);
        sb.push_back(e);
      end
      if (m_pend) begin
        if (swap) begin
          m_active = m_pending;
          m_err    = !model_perm(m_pending);
          m_pend   = 1'b0;
        end
      end else if (kv) begin
        m_pending = key;
        m_pend    = 1'b1;
      end
    end

    #1;
    exp_vld = (sb.size() > 0) && (sb[0].due == cyc);
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      e = sb.pop_front();
      check("out_sof", 32'(out_sof), 32'(e.sof));
      check("out_rgb", 32'({out_r, out_g, out_b}), 32'(e.rgb));
    end else begin
      check("idle_zero", 32'({out_sof, out_r, out_g, out_b}), 32'd0);
    end
    check("key_ready", 32'(key_ready), 32'(!m_pend));
    check("key_err", 32'(key_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'd0, 0, 0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    m_active  = 6'b00_01_10;
    m_pending = 6'b00_01_10;
    m_pend    = 1'b0;
    m_err     = 1'b0;

    // Reset state
    step(1, 0, 6'd0, 0, 0, 4'd0, 4'd0, 4'd0);
    step(1, 1, 6'b11_11_11, 1, 1, 4'hF, 4'hF, 4'hF);
    idle(1);

    // Identity: (3,5,9) -> (3,5,9)
    step(0, 0, 6'd0, 1, 1, 4'h3, 4'h5, 4'h9);
    idle(3);

    // Swap key (1,0,2) then sof pixel (A,7,2) -> (7,A,2)
    step(0, 1, 6'b01_00_10, 0, 0, 4'd0, 4'd0, 4'd0);
    step(0, 0, 6'd0, 1, 1, 4'hA, 4'h7, 4'h2);
    step(0, 0, 6'd0, 1, 0, 4'h1, 4'h2, 4'h3);
    idle(3);

    // Deferred key: accepted mid-frame, non-sof pixels keep old key
    step(0, 0, 6'd0, 1, 0, 4'h4, 4'h5, 4'h6);
    step(0, 1, 6'b10_00_01, 1, 0, 4'h7, 4'h8, 4'h9);
    step(0, 1, 6'b11_11_11, 1, 0, 4'hB, 4'hC, 4'hD);
    step(0, 0, 6'd0, 1, 0, 4'h1, 4'h2, 4'h3);
    step(0, 0, 6'd0, 0, 0, 4'd0, 4'd0, 4'd0);
    step(0, 0, 6'd0, 1, 1, 4'h1, 4'h2, 4'h3);
    step(0, 0, 6'd0, 1, 0, 4'hE, 4'h6, 4'h9);
    idle(3);

    // Key offered in the same cycle as a RUN-state sof: applies at the next sof
    step(0, 1, 6'b00_01_10, 1, 1, 4'h5, 4'h6, 4'h7);
    step(0, 0, 6'd0, 1, 0, 4'h5, 4'h6, 4'h7);
    step(0, 0, 6'd0, 1, 1, 4'h5, 4'h6, 4'h7);
    idle(3);

    // Non-invertible key (0,0,3): (4,8,C) -> (4,0,0), key_err 1
    step(0, 1, 6'b00_00_11, 0, 0, 4'd0, 4'd0, 4'd0);
    step(0, 0, 6'd0, 1, 1, 4'h4, 4'h8, 4'hC);
    idle(3);

    // Back to a valid key clears key_err
    step(0, 1, 6'b10_01_00, 0, 0, 4'd0, 4'd0, 4'd0);
    step(0, 0, 6'd0, 1, 1, 4'h1, 4'h2, 4'h3);
    idle(3);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(0, ($urandom_range(0, 5) == 0), 6'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           4'($urandom), 4'($urandom), 4'($urandom));
    end
    idle(3);

    // Reset mid-stream with two pixels in flight and a key pending
    step(0, 1, 6'b01_10_00, 0, 0, 4'd0, 4'd0, 4'd0);
    step(0, 0, 6'd0, 1, 0, 4'h9, 4'h8, 4'h7);
    step(0, 0, 6'd0, 1, 0, 4'h6, 4'h5, 4'h4);
    step(1, 0, 6'd0, 1, 1, 4'h3, 4'h2, 4'h1);
    idle(2);
    // Identity active after reset
    step(0, 0, 6'd0, 1, 1, 4'hA, 4'hB, 4'hC);
    idle(3);

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
